fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of the asynchronous FIFO among `NREQ` requesters, all in the write clock domain. It grants one requester at a time, using round-robin order and bursts of up to `MAX_BURST` words. It drives the FIFO's `winc`/`wdata` and back-pressures requesters from `wfull`. `DATASIZE` comes from the `definitions` package.

---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter: round-robin, burst-limited arbiter for the FIFO write port.
// Rev 1.0 -- define FIFO_ARB_HIPRI0_EN to give requester 0 strict priority.
// ============================================================================

package definitions;
  localparam int DATASIZE = 8;
endpackage

module fifo_wr_arbiter
  import definitions::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int LW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_nxt;
  logic [LW-1:0]   last, last_nxt;
  logic [BW-1:0]   bcnt, bcnt_nxt;
  logic [LW-1:0]   owner;
  logic            owner_valid;
  logic [LW-1:0]   pick;

  // Decode the one-hot owner; a zero grant yields zero data and no valid.
  always_comb begin
    owner       = '0;
    owner_valid = 1'b0;
    wdata       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner       = LW'(i);
        owner_valid = req_valid[i];
        wdata       = req_data[i*DATASIZE +: DATASIZE];
      end
    end
  end

  assign req_ready = wfull ? '0 : grant;
  assign winc      = owner_valid & ~wfull;
  assign busy      = (state == GRANT);

  // Two descending scans: indices above last override the wrap-around ones,
  // so the lowest valid index after last wins, else the lowest overall.
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (LW'(i) <= last)) pick = LW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (LW'(i) > last)) pick = LW'(i);
    end
`ifdef FIFO_ARB_HIPRI0_EN
    if (req_valid[0]) pick = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    bcnt_nxt  = bcnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          bcnt_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!owner_valid || (winc && (bcnt == BW'(MAX_BURST - 1)))) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          bcnt_nxt  = '0;
`ifdef FIFO_ARB_HIPRI0_EN
          if (owner != '0) last_nxt = owner;
`else
          last_nxt  = owner;
`endif
        end else if (winc) begin
          bcnt_nxt = bcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= LW'(NREQ - 1);
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a queue-level arbitration model.

module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int MB   = 4;
  localparam int DS   = definitions::DATASIZE;
  localparam int LOGN = 512;

  logic                 wclk = 1'b0;
  logic                 wrst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DS-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wfull;
  logic                 winc;
  logic [DS-1:0]        wdata;
  logic [NREQ-1:0]      grant;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  // requester word queues (circular) and enable masks
  logic [DS-1:0]   wq [NREQ][64];
  int              qh [NREQ];
  int              qc [NREQ];
  logic [NREQ-1:0] en;

  // per-cycle observations and model expectations
  int              n;
  logic [NREQ-1:0] lg_grant [LOGN];
  logic [NREQ-1:0] lg_ready [LOGN];
  logic            lg_winc  [LOGN];
  logic            lg_busy  [LOGN];
  logic [DS-1:0]   lg_wdata [LOGN];
  logic [NREQ-1:0] ex_grant [LOGN];
  logic [NREQ-1:0] ex_ready [LOGN];
  logic            ex_winc  [LOGN];
  logic            ex_busy  [LOGN];
  logic [DS-1:0]   ex_wdata [LOGN];

  // model: current owner (-1 when idle), words in this burst, last winner
  int m_owner, m_cnt, m_last;

  fifo_wr_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  function automatic int idx(input logic [NREQ-1:0] g);
    idx = -1;
    for (int i = 0; i < NREQ; i++) if (g[i]) idx = i;
  endfunction

  function automatic logic [DS-1:0] word(input int r, input int k);
    word = DS'(r * 32 + k);
  endfunction

  task automatic push(input int r, input logic [DS-1:0] v);
    wq[r][(qh[r] + qc[r]) % 64] = v;
    qc[r]++;
  endtask

  task automatic load(input int r, input int cnt);
    for (int k = 0; k < cnt; k++) push(r, word(r, k));
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (qc[i] > 0);
      req_data[i*DS +: DS] = req_valid[i] ? wq[i][qh[i]] : '0;
    end
  endtask

  task automatic clear_reqs();
    en = '0;
    for (int i = 0; i < NREQ; i++) begin
      qh[i] = 0;
      qc[i] = 0;
    end
    drive();
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NREQ - 1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    n = 0;
  endtask

  // One clock: sample at the falling edge, advance requesters and model at
  // the rising edge, then re-drive inputs 1 time unit later.
  task automatic tick();
    logic [NREQ-1:0] sv;
    logic            sf;
    int              o, pick;
    bit              rel;
    @(negedge wclk);
    sv = req_valid;
    sf = wfull;
    o  = m_owner;
    lg_grant[n] = grant;
    lg_ready[n] = req_ready;
    lg_winc[n]  = winc;
    lg_busy[n]  = busy;
    lg_wdata[n] = wdata;
    if (o >= 0) begin
      ex_grant[n] = NREQ'(1) << o;
      ex_busy[n]  = 1'b1;
      ex_winc[n]  = sv[o] & ~sf;
      ex_ready[n] = sf ? '0 : (NREQ'(1) << o);
      ex_wdata[n] = req_data[o*DS +: DS];
    end else begin
      ex_grant[n] = '0;
      ex_busy[n]  = 1'b0;
      ex_winc[n]  = 1'b0;
      ex_ready[n] = '0;
      ex_wdata[n] = '0;
    end
    @(posedge wclk);
    for (int i = 0; i < NREQ; i++) begin
      if (sv[i] && lg_ready[n][i]) begin
        qh[i] = (qh[i] + 1) % 64;
        qc[i]--;
      end
    end
    if (o < 0) begin
      if (sv != '0) begin
        pick = -1;
        for (int k = 1; k <= NREQ; k++)
          if (pick < 0 && sv[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
`ifdef FIFO_ARB_HIPRI0_EN
        if (sv[0]) pick = 0;
`endif
        m_owner = pick;
        m_cnt   = 0;
      end
    end else begin
      rel = 1'b0;
      if (!sv[o]) rel = 1'b1;
      else if (!sf) begin
        m_cnt++;
        if (m_cnt == MB) rel = 1'b1;
      end
      if (rel) begin
`ifdef FIFO_ARB_HIPRI0_EN
        if (o != 0) m_last = o;
`else
        m_last = o;
`endif
        m_owner = -1;
      end
    end
    n++;
    #1;
    drive();
  endtask

  task automatic test_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    clear_reqs();
    @(negedge wclk);
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (winc !== 1'b0) begin errors++; $display("FAIL reset_winc got %b want 0", winc); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    checks++; if (wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h want 00", wdata); end
    do_reset();
    load(1, 4);
    en = 4'b0010;
    drive();
    tick();
    tick();
    checks++; if (winc !== 1'b1) begin errors++; $display("FAIL midburst_winc got %b want 1", winc); end
    #2;
    wrst_n = 1'b0;
    #1;
    checks++; if (winc !== 1'b0 || grant !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL async_reset winc=%b grant=%b busy=%b ready=%b want all zero", winc, grant, busy, req_ready);
    end
    clear_reqs();
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
    @(posedge wclk);
    #1;
    n = 0;
    for (int i = 0; i < NREQ; i++) load(i, 4);
    en = '1;
    drive();
    tick();
    tick();
    checks++; if (lg_grant[0] !== '0) begin errors++; $display("FAIL post_reset_idle got %b want 0000", lg_grant[0]); end
    checks++; if (lg_grant[1] !== 4'b0001) begin errors++; $display("FAIL post_reset_first_grant got %b want 0001", lg_grant[1]); end
  endtask

  task automatic test_round_robin();
    int words, hits, bad, o;
    int kc [NREQ];
    logic [NREQ-1:0] eg;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8);
      kc[i] = 0;
    end
    en = '1;
    drive();
    repeat (25) tick();
    words = 0;
    for (int c = 0; c < 20; c++) if (lg_winc[c]) words++;
    checks++; if (words != 16) begin errors++; $display("FAIL rr_words_in_20 got %0d want 16", words); end
    for (int b = 0; b < 5; b++) begin
      eg = NREQ'(1) << (b % NREQ);
      checks++; if (lg_grant[5*b] !== '0) begin errors++; $display("FAIL rr_bubble_%0d got %b want 0000", b, lg_grant[5*b]); end
      hits = 0;
      for (int j = 1; j <= 4; j++) if (lg_grant[5*b+j] === eg && lg_winc[5*b+j] === 1'b1) hits++;
      checks++; if (hits != 4) begin errors++; $display("FAIL rr_burst_%0d got %0d writes by %b want 4", b, hits, eg); end
    end
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      if (lg_winc[c]) begin
        o = idx(lg_grant[c]);
        if (o < 0 || lg_wdata[c] !== word(o, kc[o])) bad++;
        if (o >= 0) kc[o]++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rr_data_order got %0d bad words want 0", bad); end
  endtask

  task automatic test_early_end();
    int hits;
    do_reset();
    load(2, 2);
    load(3, 4);
    en = 4'b1100;
    drive();
    repeat (12) tick();
    hits = 0;
    for (int c = 1; c <= 2; c++) if (lg_grant[c] === 4'b0100 && lg_winc[c] === 1'b1) hits++;
    checks++; if (hits != 2) begin errors++; $display("FAIL early_writes got %0d want 2", hits); end
    checks++; if (lg_grant[3] !== 4'b0100 || lg_winc[3] !== 1'b0) begin
      errors++; $display("FAIL early_drop_cycle grant=%b winc=%b want 0100/0", lg_grant[3], lg_winc[3]);
    end
    checks++; if (lg_grant[4] !== '0 || lg_busy[4] !== 1'b0) begin
      errors++; $display("FAIL early_release grant=%b busy=%b want 0000/0", lg_grant[4], lg_busy[4]);
    end
    checks++; if (lg_grant[5] !== 4'b1000) begin errors++; $display("FAIL early_next_grant got %b want 1000", lg_grant[5]); end
  endtask

  task automatic test_full_stall();
    int bad, words;
    do_reset();
    load(0, 8);
    en = 4'b0001;
    drive();
    for (int c = 0; c < 12; c++) begin
      wfull = (c >= 3 && c <= 7);
      tick();
    end
    wfull = 1'b0;
    bad = 0;
    for (int c = 3; c <= 7; c++)
      if (lg_winc[c] !== 1'b0 || lg_ready[c] !== '0 || lg_grant[c] !== 4'b0001 || lg_busy[c] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    checks++; if (lg_winc[8] !== 1'b1 || lg_winc[9] !== 1'b1) begin
      errors++; $display("FAIL stall_resume winc8=%b winc9=%b want 1/1", lg_winc[8], lg_winc[9]);
    end
    words = 0;
    for (int c = 0; c < 10; c++) if (lg_winc[c]) words++;
    checks++; if (words != 4) begin errors++; $display("FAIL stall_burst_words got %0d want 4", words); end
    checks++; if (lg_grant[10] !== '0 || lg_grant[11] !== 4'b0001) begin
      errors++; $display("FAIL stall_rearb grant10=%b grant11=%b want 0000/0001", lg_grant[10], lg_grant[11]);
    end
  endtask

  task automatic test_single();
    int bad, words, k;
    logic ew;
    do_reset();
    load(1, 10);
    en = 4'b0010;
    drive();
    repeat (16) tick();
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      ew = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 12);
      if (lg_winc[c] !== ew) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_pattern got %0d bad cycles want 0", bad); end
    checks++; if (lg_grant[5] !== '0 || lg_grant[10] !== '0) begin
      errors++; $display("FAIL single_bubbles grant5=%b grant10=%b want 0000/0000", lg_grant[5], lg_grant[10]);
    end
    checks++; if (lg_grant[13] !== 4'b0010 || lg_grant[14] !== '0) begin
      errors++; $display("FAIL single_tail grant13=%b grant14=%b want 0010/0000", lg_grant[13], lg_grant[14]);
    end
    words = 0;
    k = 0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      if (lg_winc[c]) begin
        words++;
        if (lg_wdata[c] !== word(1, k)) bad++;
        k++;
      end
    end
    checks++; if (words != 10 || bad != 0) begin
      errors++; $display("FAIL single_data got %0d words %0d wrong want 10 words 0 wrong", words, bad);
    end
  endtask

  task automatic test_hipri();
    int eo;
    do_reset();
    load(0, 20);
    load(3, 20);
    en = 4'b1001;
    drive();
    repeat (21) tick();
    for (int b = 0; b < 4; b++) begin
`ifdef FIFO_ARB_HIPRI0_EN
      eo = 0;
`else
      eo = (b % 2 == 0) ? 0 : 3;
`endif
      checks++; if (lg_grant[1+5*b] !== (NREQ'(1) << eo)) begin
        errors++; $display("FAIL hipri_grant_%0d got %b want %b", b, lg_grant[1+5*b], NREQ'(1) << eo);
      end
    end
  endtask

  task automatic test_random();
    int c;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (qc[i] < 8) push(i, DS'($urandom));
        en[i] = ($urandom_range(0, 3) != 0);
      end
      wfull = ($urandom_range(0, 4) == 0);
      drive();
      tick();
      c = n - 1;
      checks++; if (lg_grant[c] !== ex_grant[c]) begin errors++; $display("FAIL rand_grant cyc %0d got %b want %b", c, lg_grant[c], ex_grant[c]); end
      checks++; if (lg_winc[c] !== ex_winc[c]) begin errors++; $display("FAIL rand_winc cyc %0d got %b want %b", c, lg_winc[c], ex_winc[c]); end
      checks++; if (lg_ready[c] !== ex_ready[c]) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, lg_ready[c], ex_ready[c]); end
      checks++; if (lg_wdata[c] !== ex_wdata[c]) begin errors++; $display("FAIL rand_wdata cyc %0d got %h want %h", c, lg_wdata[c], ex_wdata[c]); end
      checks++; if (lg_busy[c] !== ex_busy[c]) begin errors++; $display("FAIL rand_busy cyc %0d got %b want %b", c, lg_busy[c], ex_busy[c]); end
    end
    wfull = 1'b0;
  endtask

  initial begin
    wrst_n    = 1'b0;
    wfull     = 1'b0;
    en        = '0;
    req_valid = '0;
    req_data  = '0;
    n         = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_early_end();
    test_full_stall();
    test_single();
    test_hipri();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
